// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between the ALU writeback stage and a small
// LSU result FIFO, with starvation forcing and a WAW interlock.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            wenable,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wdata,
  output logic [31:0]     pending
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [4:0]      buf_rd   [BUF_DEPTH];
  logic [XLEN-1:0] buf_data [BUF_DEPTH];

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   count;
  logic [AW-1:0] slot_ofs;
  logic          empty;
  logic          full;

  logic [SW-1:0] starve_cnt;
  logic          force_drain;
  logic          waw;
  logic          fifo_grant;
  logic          alu_grant;
  logic          push;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    pending  = '0;
    slot_ofs = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        slot_ofs = AW'(i) - rd_idx;
        if ({1'b0, slot_ofs} < count) begin
          pending[buf_rd[i]] = 1'b1;
        end
      end
    end
  end

  assign force_drain = !empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign waw         = alu_valid && (alu_rd != 5'd0) && pending[alu_rd];
  assign fifo_grant  = !rst && !empty && (force_drain || waw || !alu_valid);
  assign alu_grant   = !rst && alu_valid && !fifo_grant;
  assign alu_stall   = !rst && alu_valid && (force_drain || waw);
  assign mem_ready   = !rst && !full;
  assign push        = mem_valid && mem_ready && (mem_rd != 5'd0);

  always_comb begin
    wenable = 1'b0;
    rd      = '0;
    wdata   = '0;
    if (fifo_grant) begin
      wenable = 1'b1;
      rd      = buf_rd[rd_idx];
      wdata   = buf_data[rd_idx];
    end else if (alu_grant) begin
      wenable = (alu_rd != 5'd0);
      rd      = alu_rd;
      wdata   = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (fifo_grant) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (empty || fifo_grant) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[wr_idx]   <= mem_rd;
      buf_data[wr_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised + directed bench for regfile_wb_arbiter against a queue-based
// reference model of the writeback arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wenable;
  logic [4:0]      rd;
  logic [XLEN-1:0] wdata;
  logic [31:0]     pending;

  regfile_wb_arbiter #(
    .XLEN(XLEN),
    .BUF_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wenable(wenable), .rd(rd), .wdata(wdata), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int unsigned mstarve = 0;

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (mq[k]) p[mq[k].rd] = 1'b1;
    return p;
  endfunction

  function automatic bit m_blocked();
    logic [31:0] p = m_pending();
    bit frc = (mq.size() != 0) && (mstarve == LIMIT);
    bit w   = alu_valid && (alu_rd != 0) && p[alu_rd];
    return frc || w;
  endfunction

  function automatic bit m_fifo_wins();
    return (mq.size() != 0) && (m_blocked() || !alu_valid);
  endfunction

  always @(posedge clk) begin
    bit fw, accept, was_empty;
    if (rst) begin
      mq.delete();
      mstarve = 0;
    end else begin
      fw        = m_fifo_wins();
      accept    = mem_valid && (mq.size() < DEPTH);
      was_empty = (mq.size() == 0);
      if (fw) void'(mq.pop_front());
      if (accept && mem_rd != 0) mq.push_back('{rd: mem_rd, data: mem_data});
      if (was_empty || fw) mstarve = 0;
      else if (mstarve < LIMIT) mstarve++;
    end
  end

  logic [31:0] obs [32];
  always @(posedge clk) if (wenable) obs[rd] <= wdata;

  always @(negedge clk) begin
    bit          fw, ewe;
    logic [4:0]  erd;
    logic [31:0] ewd;
    if (rst) begin
      ck("rst_mem_ready", mem_ready, 0);
      ck("rst_alu_stall", alu_stall, 0);
      ck("rst_wenable", wenable, 0);
      ck("rst_pending", pending, 0);
      ck("rst_rd", rd, 0);
      ck("rst_wdata", wdata, 0);
    end else begin
      fw  = m_fifo_wins();
      ewe = fw || (alu_valid && alu_rd != 0);
      erd = fw ? mq[0].rd : alu_rd;
      ewd = fw ? mq[0].data : alu_data;
      ck("mem_ready", mem_ready, mq.size() < DEPTH);
      ck("alu_stall", alu_stall, alu_valid && m_blocked());
      ck("wenable", wenable, ewe);
      ck("pending", pending, m_pending());
      if (ewe) begin
        ck("rd", rd, erd);
        ck("wdata", wdata, ewd);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
    alu_valid = v; alu_rd = r; alu_data = d;
  endtask

  task automatic mem(input logic v, input logic [4:0] r, input logic [31:0] d);
    mem_valid = v; mem_rd = r; mem_data = d;
  endtask

  initial begin
    bit hold_a, hold_m;
    rst = 1'b1;
    alu(1, 4, 32'h44);
    mem(1, 6, 32'h66);
    next(); next();
    mid();
    ck("lit_rst_wenable", wenable, 0);
    ck("lit_rst_ready", mem_ready, 0);
    ck("lit_rst_pending", pending, 0);
    next();
    rst = 1'b0; alu(0, 0, 0); mem(0, 0, 0);

    // ALU-only stream
    for (int r = 1; r <= 8; r++) begin
      alu(1, 5'(r), 32'h100 + r);
      mid();
      ck("lit_alu_we", wenable, 1);
      ck("lit_alu_rd", rd, r);
      ck("lit_alu_wdata", wdata, 32'h100 + r);
      ck("lit_alu_stall", alu_stall, 0);
      next();
    end
    alu(0, 0, 0);
    for (int r = 1; r <= 8; r++) ck("lit_x_readback", obs[r], 32'h100 + r);

    // LSU under idle ALU
    mem(1, 5, 32'hDEADBEEF);
    mid();
    ck("lit_lsu_ready", mem_ready, 1);
    ck("lit_lsu_pend_before", pending, 0);
    next();
    mem(0, 0, 0);
    mid();
    ck("lit_lsu_pend", pending, 32'h20);
    ck("lit_lsu_we", wenable, 1);
    ck("lit_lsu_rd", rd, 5);
    ck("lit_lsu_wdata", wdata, 32'hDEADBEEF);
    next();
    mid();
    ck("lit_lsu_pend_after", pending, 0);
    ck("lit_lsu_we_after", wenable, 0);
    next();

    // Starvation
    mem(1, 3, 32'hA5);
    alu(1, 7, 32'h77);
    mid();
    ck("lit_stv_push_rd", rd, 7);
    next();
    mem(0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      mid();
      if (k == 5) begin
        ck("lit_stv_force_stall", alu_stall, 1);
        ck("lit_stv_force_rd", rd, 3);
        ck("lit_stv_force_wdata", wdata, 32'hA5);
      end else begin
        ck("lit_stv_stall", alu_stall, 0);
        ck("lit_stv_rd", rd, 7);
      end
      next();
    end
    alu(0, 0, 0);

    // WAW interlock
    mem(1, 9, 32'h11);
    mid();
    next();
    mem(0, 0, 0);
    alu(1, 9, 32'h22);
    mid();
    ck("lit_waw_stall", alu_stall, 1);
    ck("lit_waw_rd", rd, 9);
    ck("lit_waw_old", wdata, 32'h11);
    next();
    mid();
    ck("lit_waw_stall2", alu_stall, 0);
    ck("lit_waw_new", wdata, 32'h22);
    next();
    alu(0, 0, 0);
    ck("lit_waw_x9", obs[9], 32'h22);

    // Full / back-pressure
    alu(1, 10, 32'hAA);
    mem(1, 11, 32'h1);
    mid();
    ck("lit_full_ready0", mem_ready, 1);
    next();
    mem(1, 12, 32'h2);
    mid();
    ck("lit_full_ready1", mem_ready, 1);
    next();
    mem(1, 13, 32'h3);
    mid();
    ck("lit_full_ready2", mem_ready, 0);
    ck("lit_full_pend", pending, 32'h1800);
    next();
    mid();
    ck("lit_full_ready3", mem_ready, 0);
    ck("lit_full_alu_rd", rd, 10);
    next();
    alu(0, 0, 0);
    mid();
    ck("lit_full_nobypass", mem_ready, 0);
    ck("lit_full_drain_rd", rd, 11);
    next();
    mid();
    ck("lit_full_ready4", mem_ready, 1);
    ck("lit_full_drain_rd2", rd, 12);
    next();
    mem(0, 0, 0);
    mid();
    ck("lit_full_drain_rd3", rd, 13);
    next();

    // rd = 0 requests
    mem(1, 0, 32'h55);
    mid();
    ck("lit_rd0_ready", mem_ready, 1);
    next();
    mem(0, 0, 0);
    mid();
    ck("lit_rd0_pend", pending, 0);
    ck("lit_rd0_we", wenable, 0);
    next();
    alu(1, 0, 32'h99);
    mid();
    ck("lit_alu_rd0_we", wenable, 0);
    ck("lit_alu_rd0_stall", alu_stall, 0);
    next();
    alu(0, 0, 0);

    // Reset mid-operation
    alu(1, 20, 32'h20);
    mem(1, 14, 32'h14);
    mid(); next();
    mem(1, 15, 32'h15);
    mid(); next();
    rst = 1'b1;
    mem(1, 16, 32'h16);
    mid();
    ck("lit_mrst_we", wenable, 0);
    ck("lit_mrst_stall", alu_stall, 0);
    ck("lit_mrst_ready", mem_ready, 0);
    ck("lit_mrst_pend", pending, 0);
    ck("lit_mrst_rd", rd, 0);
    ck("lit_mrst_wdata", wdata, 0);
    next();
    rst = 1'b0; alu(0, 0, 0); mem(0, 0, 0);
    mid();
    ck("lit_post_pend", pending, 0);
    ck("lit_post_ready", mem_ready, 1);
    ck("lit_post_we", wenable, 0);
    next();
    mid();
    ck("lit_post_we2", wenable, 0);

    // Randomised traffic obeying the hold protocols
    for (int c = 0; c < 3000; c++) begin
      hold_a = alu_valid && alu_stall;
      hold_m = mem_valid && !mem_ready && !rst;
      next();
      rst = ($urandom_range(0, 99) == 0);
      if (!hold_a) alu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 9)), $urandom);
      if (!hold_m) mem($urandom_range(0, 2) == 0, 5'($urandom_range(0, 9)), $urandom);
      mid();
    end

    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
